sender_tx_sched: RTL and testbench
==================================

Name: sender_tx_sched

Overview:
- Schedules the sender's single shared transmit engine among four periodic traffic classes: 6.25k, 3.125k, 1k and 1 Hz.
- Class triggers come from the sender timing block (tri_6k, tri_3k, tri_1k, sec_p).
- Latches each trigger as a pending request and grants the engine to one class at a time by fixed priority, through a req/ack/done handshake.
- Counts overruns per class and aborts stuck transfers with a watchdog.

Parameters:
- NCH, 4, number of request classes; channel 0 has highest priority.
- TMO_CYC, 16'd12000, max cycles in BUSY before abort (96 us at 125 MHz).
- OVR_W, 8, width of each saturating overrun counter.

Ports:
- sysclk  in  1  system clock, 125 MHz.
- nrst  in  1  reset, synchronous, active-low. Sampled only on the sysclk rising edge.
- trig  in  NCH  class triggers, level or pulse. Bit0 = tri_6k, bit1 = tri_3k, bit2 = tri_1k, bit3 = sec_p.
- ch_en  in  NCH  per-class enable. A disabled class ignores triggers and its pending bit is cleared.
- cnt_clr  in  1  one-cycle pulse that clears all overrun counters.
- tx_req  out  1  request to the transmit engine.
- tx_ch  out  2  channel index of the current grant; stable while tx_req or busy is high.
- tx_ack  in  1  engine accepted the request.
- tx_done  in  1  one-cycle pulse: engine finished the current frame.
- busy  out  1  high from grant issue until done or abort.
- pend  out  NCH  pending request flags.
- ovr_cnt  out  NCH*OVR_W  packed saturating overrun counters; channel 0 in the LSBs.
- tmo_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (nrst=0 at a clock edge): tx_req=0, tx_ch=0, busy=0, pend=0, ovr_cnt=0, tmo_err=0, FSM=IDLE, trigger edge registers=0. Reset mid-transfer abandons the grant silently; no tmo_err is raised.
- Trigger edge detect:
  - Register trig once.
  - trig_rise = trig & ~trig_q.
  - A trigger held high creates only one request.
- Pending bit p[i]:
  - Set on trig_rise[i] & ch_en[i].
  - Cleared when channel i is granted, i.e. on the IDLE->REQ transition.
  - Forced to 0 while ch_en[i]=0.
- Overrun: trig_rise[i] & ch_en[i] while p[i] is already 1, or while channel i is the active grant (REQ or BUSY).
  - Increments ovr_cnt[i], saturating at all-ones.
  - p[i] stays 1; the request is not duplicated.
- Rise on the same cycle p[i] clears due to grant: p[i] is re-set and the event is counted as an overrun.
- cnt_clr: zeroes all counters. If it coincides with an overrun event, the clear wins and the counter ends at 0.
- FSM states IDLE, REQ, BUSY:
  - IDLE: if any p is set, pick the lowest set index k. Next cycle tx_ch=k, tx_req=1, busy=1, state=REQ. Arbitration to tx_req takes 1 cycle.
  - REQ: hold tx_req and tx_ch until tx_ack=1. On the tx_ack cycle, state->BUSY and tx_req deasserts on the next edge.
  - REQ: tx_done with no ack is ignored.
  - BUSY: on tx_done, state->IDLE and busy=0 next cycle. The earliest next grant is the cycle after that, giving 1 idle cycle minimum between grants.
  - tx_ack and tx_done in the same REQ cycle: treated as ack then done, going directly to IDLE.
- Watchdog:
  - 16-bit counter, cleared on entering REQ, increments in REQ and BUSY.
  - Reaching TMO_CYC-1 without tx_done: state->IDLE, tx_req=0, busy=0, tmo_err=1 for 1 cycle.
  - The aborted request is dropped, not re-queued.
- Disable mid-grant: clearing ch_en[tx_ch] does not abort an active grant; only the pending bit is affected.
- Priority: strict fixed order. Lower classes may starve only if higher-class load reaches 100%; that is accepted by design given the trigger rates.

Decomposition:
- Shared package sender_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_REQ=2'd1, ST_BUSY=2'd2;
  - channel index constants CH_6K=0, CH_3K=1, CH_1K=2, CH_SEC=3;
  - the default TMO_CYC.
- One sub-module, sched_pend_ch, instantiated NCH times. It contains edge detect, pending bit and saturating overrun counter.
- The FSM, priority encoder and watchdog stay in the top.

Test Plan:
- Single trigger: one pulse on trig[2], ack after 3 cycles, done after 10 more. Expect tx_req 1 cycle after the rise, tx_ch=2, busy high for 14 cycles, pend=0 afterward, ovr_cnt=0.
- Priority: trig[3] and trig[0] rise in the same cycle. Expect first grant tx_ch=0, then tx_ch=3 on the 2nd cycle after done.
- Overrun: trig[1] fires 3 times while channel 1 is BUSY. Expect ovr_cnt[1]=3 and pend[1]=1. Then 300 overrun events saturate it at 255; cnt_clr returns it to 0.
- Watchdog: TMO_CYC=100, grant acked, tx_done never sent. Expect tmo_err pulse 100 cycles after entering REQ, busy=0, next pending channel granted.
- Level trigger plus disable: trig[0] held high for 50 cycles gives exactly 1 grant. ch_en[2]=0 with pulses on trig[2] gives no pend and no grant.
- Reset mid-BUSY: assert nrst=0 for 1 cycle. At the next edge all outputs are 0, state is IDLE and tmo_err stays 0.

Source files
------------

// File: rtl/sender_pkg.sv
// Shared types and constants for the sender transmit scheduler.
package sender_pkg;

   localparam int unsigned NCH_DEF   = 4;
   localparam int unsigned CH_W      = 2;
   localparam int unsigned OVR_W_DEF = 8;
   localparam int unsigned WDOG_W    = 16;

   localparam logic [WDOG_W-1:0] TMO_CYC_DEF = 16'd12000;

   // Traffic class to channel mapping; lower index wins arbitration.
   localparam int unsigned CH_6K  = 0;
   localparam int unsigned CH_3K  = 1;
   localparam int unsigned CH_1K  = 2;
   localparam int unsigned CH_SEC = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_BUSY = 2'd2
   } state_e;

endpackage

// File: rtl/sender_tx_sched_if.sv
// Grant handshake between the scheduler (master) and the transmit engine (slave).
interface sender_tx_sched_if;

   logic                         tx_req;
   logic [sender_pkg::CH_W-1:0]  tx_ch;
   logic                         busy;
   logic                         tx_ack;
   logic                         tx_done;

   modport master (output tx_req, tx_ch, busy, input tx_ack, tx_done);
   modport slave  (input tx_req, tx_ch, busy, output tx_ack, tx_done);

endinterface

// File: rtl/sched_pend_ch.sv
// Per-class trigger edge detect, pending flag and saturating overrun counter.
module sched_pend_ch #(
   parameter int unsigned OVR_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             trig_i,
   input  logic             en_i,
   input  logic             gnt_i,
   input  logic             active_i,
   input  logic             cnt_clr_i,
   output logic             pend_o,
   output logic [OVR_W-1:0] ovr_cnt_o
);

   logic             trig_q;
   logic             pend_q, pend_d;
   logic [OVR_W-1:0] cnt_q, cnt_d;
   logic             rise;
   logic             ovr;

   assign rise = trig_i & ~trig_q;

   // A rise on the grant cycle sees pend_q=1, so it re-arms and counts as overrun.
   always_comb begin
      ovr    = rise & en_i & (pend_q | active_i);
      pend_d = en_i & ((pend_q & ~gnt_i) | rise);
      cnt_d  = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (ovr && (cnt_q != '1)) begin
         cnt_d = cnt_q + OVR_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         trig_q <= 1'b0;
         pend_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         trig_q <= trig_i;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pend_o    = pend_q;
   assign ovr_cnt_o = cnt_q;

endmodule

// File: rtl/sender_tx_sched.sv
// Fixed-priority scheduler granting the shared transmit engine to periodic traffic classes,
// with a watchdog that drops transfers the engine never completes.
module sender_tx_sched
   import sender_pkg::*;
#(
   parameter int unsigned       NCH     = NCH_DEF,
   parameter int unsigned       OVR_W   = OVR_W_DEF,
   parameter logic [WDOG_W-1:0] TMO_CYC = TMO_CYC_DEF
) (
   input  logic                   sysclk,
   input  logic                   nrst,
   input  logic [NCH-1:0]         trig,
   input  logic [NCH-1:0]         ch_en,
   input  logic                   cnt_clr,
   sender_tx_sched_if.master      tx,
   output logic [NCH-1:0]         pend,
   output logic [NCH*OVR_W-1:0]   ovr_cnt,
   output logic                   tmo_err
);

   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              req_q, req_d;
   logic              busy_q, busy_d;
   logic              tmo_q, tmo_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [NCH-1:0]    gnt;
   logic [NCH-1:0]    active;
   logic [CH_W-1:0]   pick;
   logic              wdog_hit;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      sched_pend_ch #(.OVR_W(OVR_W)) u_ch (
         .clk_i     (sysclk),
         .rst_ni    (nrst),
         .trig_i    (trig[g]),
         .en_i      (ch_en[g]),
         .gnt_i     (gnt[g]),
         .active_i  (active[g]),
         .cnt_clr_i (cnt_clr),
         .pend_o    (pend[g]),
         .ovr_cnt_o (ovr_cnt[g*OVR_W +: OVR_W])
      );
   end

   // Lowest set pending index wins.
   always_comb begin
      pick = '0;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (pend[i]) pick = CH_W'(i);
      end
   end

   assign active   = (state_q != ST_IDLE) ? (NCH'(1) << ch_q) : '0;
   assign wdog_hit = (wdog_q == (TMO_CYC - WDOG_W'(1)));

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      wdog_d  = wdog_q;
      tmo_d   = 1'b0;
      gnt     = '0;
      case (state_q)
         ST_IDLE: begin
            if (|pend) begin
               state_d = ST_REQ;
               ch_d    = pick;
               wdog_d  = '0;
               gnt     = NCH'(1) << pick;
            end
         end
         ST_REQ: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (tx.tx_ack && tx.tx_done) begin
               state_d = ST_IDLE;
            end else if (wdog_hit) begin
               state_d = ST_IDLE;
               tmo_d   = 1'b1;
            end else if (tx.tx_ack) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (tx.tx_done) begin
               state_d = ST_IDLE;
            end else if (wdog_hit) begin
               state_d = ST_IDLE;
               tmo_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_d  = (state_d == ST_REQ);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge sysclk) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
         wdog_q  <= wdog_d;
      end
   end

   assign tx.tx_req = req_q;
   assign tx.tx_ch  = ch_q;
   assign tx.busy   = busy_q;
   assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_sender_tx_sched.sv
// Directed bench for sender_tx_sched with a shortened watchdog (100 cycles).
module tb_sender_tx_sched;

   logic        sysclk = 1'b0;
   logic        nrst;
   logic [3:0]  trig;
   logic [3:0]  ch_en;
   logic        cnt_clr;
   logic [3:0]  pend;
   logic [31:0] ovr_cnt;
   logic        tmo_err;
   int          checks = 0;
   int          errors = 0;

   sender_tx_sched_if tx_if ();

   sender_tx_sched #(.NCH(4), .OVR_W(8), .TMO_CYC(16'd100)) dut (
      .sysclk  (sysclk),
      .nrst    (nrst),
      .trig    (trig),
      .ch_en   (ch_en),
      .cnt_clr (cnt_clr),
      .tx      (tx_if),
      .pend    (pend),
      .ovr_cnt (ovr_cnt),
      .tmo_err (tmo_err)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(negedge sysclk);
   endtask

   // Engine model: ack any request, finish at once; stop when idle with nothing pending.
   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
         if (!tx_if.busy && !tx_if.tx_req && pend == 4'd0) begin
            ok = 1'b1;
         end else begin
            tx_if.tx_ack  = tx_if.tx_req;
            tx_if.tx_done = tx_if.busy;
            tick();
         end
      end
      tx_if.tx_ack  = 1'b0;
      tx_if.tx_done = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain: scheduler still busy=%b pend=%b", tx_if.busy, pend);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; trig = '0; ch_en = 4'hF; cnt_clr = 1'b0;
      tx_if.tx_ack = 1'b0; tx_if.tx_done = 1'b0;
      tick(); tick();
      checks++;
      if ({tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend, ovr_cnt, tmo_err} !== 41'd0) begin
         errors++;
         $display("FAIL reset: req=%b busy=%b ch=%0d pend=%b ovr=%h tmo=%b exp all 0",
                  tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend, ovr_cnt, tmo_err);
      end
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int busy_cnt = 0;
      trig[2] = 1'b1; tick(); trig[2] = 1'b0;
      checks++;
      if ({tx_if.tx_req, pend} !== 5'b0_0100) begin
         errors++;
         $display("FAIL single_pend: req=%b pend=%b exp req=0 pend=0100", tx_if.tx_req, pend);
      end
      tick();
      checks++;
      if ({tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend} !== {1'b1, 1'b1, 2'd2, 4'd0}) begin
         errors++;
         $display("FAIL single_grant: req=%b busy=%b ch=%0d pend=%b exp 1 1 2 0000",
                  tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend);
      end
      for (int k = 0; k < 20; k++) begin
         if (tx_if.busy) busy_cnt++;
         if (k == 3) begin
            checks++;
            if ({tx_if.tx_req, tx_if.tx_ch} !== {1'b0, 2'd2}) begin
               errors++;
               $display("FAIL single_ack: req=%b ch=%0d exp req=0 ch=2", tx_if.tx_req, tx_if.tx_ch);
            end
         end
         tx_if.tx_ack  = (k == 2);
         tx_if.tx_done = (k == 13);
         tick();
      end
      checks++;
      if (busy_cnt != 14) begin
         errors++;
         $display("FAIL single_busy_len: got %0d exp 14", busy_cnt);
      end
      checks++;
      if ({pend, ovr_cnt, tmo_err} !== 37'd0) begin
         errors++;
         $display("FAIL single_after: pend=%b ovr=%h tmo=%b exp 0", pend, ovr_cnt, tmo_err);
      end
   endtask

   task automatic test_priority();
      trig = 4'b1001; tick(); trig = '0;
      checks++;
      if (pend !== 4'b1001) begin
         errors++;
         $display("FAIL prio_pend: got %b exp 1001", pend);
      end
      tick();
      checks++;
      if ({tx_if.tx_req, tx_if.tx_ch, pend} !== {1'b1, 2'd0, 4'b1000}) begin
         errors++;
         $display("FAIL prio_first: req=%b ch=%0d pend=%b exp 1 0 1000", tx_if.tx_req, tx_if.tx_ch, pend);
      end
      tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
      tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
      checks++;
      if ({tx_if.tx_req, tx_if.busy} !== 2'b00) begin
         errors++;
         $display("FAIL prio_done: req=%b busy=%b exp 0 0", tx_if.tx_req, tx_if.busy);
      end
      tick();
      checks++;
      if ({tx_if.tx_req, tx_if.tx_ch, pend} !== {1'b1, 2'd3, 4'b0000}) begin
         errors++;
         $display("FAIL prio_second: req=%b ch=%0d pend=%b exp 1 3 0000", tx_if.tx_req, tx_if.tx_ch, pend);
      end
      tx_if.tx_ack = 1'b1; tx_if.tx_done = 1'b1; tick();
      tx_if.tx_ack = 1'b0; tx_if.tx_done = 1'b0;
      checks++;
      if ({tx_if.tx_req, tx_if.busy} !== 2'b00) begin
         errors++;
         $display("FAIL ack_done_same: req=%b busy=%b exp 0 0", tx_if.tx_req, tx_if.busy);
      end
      tick();
   endtask

   task automatic test_overrun();
      trig[1] = 1'b1; tick(); trig[1] = 1'b0; tick();
      tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
      repeat (3) begin
         trig[1] = 1'b1; tick(); trig[1] = 1'b0; tick();
      end
      checks++;
      if ({tx_if.busy, tx_if.tx_ch, ovr_cnt[15:8], pend} !== {1'b1, 2'd1, 8'd3, 4'b0010}) begin
         errors++;
         $display("FAIL ovr_three: busy=%b ch=%0d ovr1=%0d pend=%b exp 1 1 3 0010",
                  tx_if.busy, tx_if.tx_ch, ovr_cnt[15:8], pend);
      end
      tx_if.tx_done = 1'b1; tick(); tx_if.tx_done = 1'b0;
      repeat (300) begin
         trig[1] = 1'b1; tick(); trig[1] = 1'b0; tick();
      end
      checks++;
      if (ovr_cnt !== 32'h0000_FF00) begin
         errors++;
         $display("FAIL ovr_saturate: got %h exp 0000ff00", ovr_cnt);
      end
      trig[1] = 1'b1; cnt_clr = 1'b1; tick();
      trig[1] = 1'b0; cnt_clr = 1'b0;
      checks++;
      if (ovr_cnt !== 32'd0) begin
         errors++;
         $display("FAIL ovr_clr_wins: got %h exp 0", ovr_cnt);
      end
      drain();
   endtask

   task automatic test_watchdog();
      int bad = 0;
      trig = 4'b0110; tick(); trig = '0; tick();
      checks++;
      if ({tx_if.tx_req, tx_if.tx_ch, pend} !== {1'b1, 2'd1, 4'b0100}) begin
         errors++;
         $display("FAIL wd_grant: req=%b ch=%0d pend=%b exp 1 1 0100", tx_if.tx_req, tx_if.tx_ch, pend);
      end
      tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
      for (int k = 1; k < 100; k++) begin
         if (tmo_err !== 1'b0 || tx_if.busy !== 1'b1) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wd_early: %0d cycles with tmo_err or busy wrong, exp 0", bad);
      end
      checks++;
      if ({tmo_err, tx_if.busy, tx_if.tx_req} !== 3'b100) begin
         errors++;
         $display("FAIL wd_abort: tmo=%b busy=%b req=%b exp 1 0 0", tmo_err, tx_if.busy, tx_if.tx_req);
      end
      tick();
      checks++;
      if ({tmo_err, tx_if.tx_req, tx_if.tx_ch, pend} !== {1'b0, 1'b1, 2'd2, 4'd0}) begin
         errors++;
         $display("FAIL wd_next: tmo=%b req=%b ch=%0d pend=%b exp 0 1 2 0000",
                  tmo_err, tx_if.tx_req, tx_if.tx_ch, pend);
      end
      drain();
   endtask

   task automatic test_level_disable();
      int  grants = 0;
      int  bad    = 0;
      logic prev  = 1'b0;
      trig[0] = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (tx_if.tx_req && !prev) grants++;
         prev = tx_if.tx_req;
         tx_if.tx_ack  = tx_if.tx_req;
         tx_if.tx_done = tx_if.busy;
         tick();
      end
      trig[0] = 1'b0;
      drain();
      checks++;
      if (grants != 1 || ovr_cnt[7:0] !== 8'd0) begin
         errors++;
         $display("FAIL level_trig: grants=%0d ovr0=%0d exp 1 0", grants, ovr_cnt[7:0]);
      end
      ch_en = 4'b1011;
      repeat (3) begin
         trig[2] = 1'b1; tick();
         if (pend !== 4'd0 || tx_if.tx_req !== 1'b0) bad++;
         trig[2] = 1'b0; tick();
         if (pend !== 4'd0 || tx_if.tx_req !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || ovr_cnt[23:16] !== 8'd0) begin
         errors++;
         $display("FAIL disabled_ch: %0d bad samples ovr2=%0d exp 0 0", bad, ovr_cnt[23:16]);
      end
      ch_en = 4'hF;
      tick();
   endtask

   task automatic test_reset_mid_busy();
      int bad = 0;
      trig[3] = 1'b1; tick(); trig[3] = 1'b0; tick();
      tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
      trig[3] = 1'b1; tick(); trig[3] = 1'b0; tick();
      checks++;
      if ({tx_if.busy, ovr_cnt[31:24], pend} !== {1'b1, 8'd1, 4'b1000}) begin
         errors++;
         $display("FAIL pre_reset: busy=%b ovr3=%0d pend=%b exp 1 1 1000", tx_if.busy, ovr_cnt[31:24], pend);
      end
      nrst = 1'b0; tick(); nrst = 1'b1;
      checks++;
      if ({tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend, ovr_cnt, tmo_err} !== 41'd0) begin
         errors++;
         $display("FAIL reset_mid_busy: req=%b busy=%b ch=%0d pend=%b ovr=%h tmo=%b exp all 0",
                  tx_if.tx_req, tx_if.busy, tx_if.tx_ch, pend, ovr_cnt, tmo_err);
      end
      repeat (5) begin
         tick();
         if ({tmo_err, tx_if.busy, tx_if.tx_req} !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_reset_idle: %0d bad samples exp 0", bad);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_overrun();
      test_watchdog();
      test_level_disable();
      test_reset_mid_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
